// File: rtl/burst_round_robin_arbiter.sv
// burst_round_robin_arbiter: round-robin arbiter that locks the grant for a whole burst.
// Define BURST_ROUND_ROBIN_ARBITER_IDLE_RELEASE_EN to drop a lock after IDLE_TIMEOUT request-free cycles.
module burst_round_robin_arbiter #(
  parameter int SIZE = 4,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [SIZE-1:0]         requests,
  input  logic [SIZE-1:0]         lasts,
  input  logic                    ready,
  output logic [SIZE-1:0]         grant,
  output logic [$clog2(SIZE)-1:0] grant_index,
  output logic                    locked
);
  localparam int PW = $clog2(SIZE);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_next;
  logic [PW-1:0] pointer, pointer_next, locked_index, locked_index_next;
  logic [PW-1:0] scan_index, cur_index, cur_next, k;
  logic [BW-1:0] beat_count, beat_next;
  logic [SIZE-1:0] cur_grant;
  logic scan_found, transfer, release_burst, idle_release;
  if (SIZE < 2 || MAX_BURST < 1 || IDLE_TIMEOUT < 1) begin : g_bad_params
    $error("burst_round_robin_arbiter: invalid parameters");
  end
  // Scan from the highest offset down so the lowest offset from pointer wins.
  always_comb begin
    scan_found = 1'b0;
    scan_index = '0;
    k = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      k = PW'((int'(pointer) + i) % SIZE);
      if (requests[k]) begin
        scan_found = 1'b1;
        scan_index = k;
      end
    end
    cur_index = state == LOCKED ? locked_index : scan_index;
    cur_grant = (state == LOCKED || scan_found) ? SIZE'(1) << cur_index : '0;
    transfer = |(cur_grant & requests) & ready;
    cur_next = cur_index == PW'(SIZE - 1) ? '0 : cur_index + 1'b1;
    release_burst = transfer && (lasts[cur_index] ||
                    (state == LOCKED ? beat_count + 1'b1 == BW'(MAX_BURST) : MAX_BURST == 1));
  end
`ifdef BURST_ROUND_ROBIN_ARBITER_IDLE_RELEASE_EN
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  logic [IW-1:0] idle_count, idle_next;
  logic idle_cycle;
  always_comb begin
    idle_cycle = state == LOCKED && !requests[locked_index];
    idle_release = idle_cycle && idle_count + 1'b1 == IW'(IDLE_TIMEOUT);
    idle_next = (idle_cycle && !idle_release) ? idle_count + 1'b1 : '0;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) idle_count <= '0;
    else idle_count <= idle_next;
`else
  assign idle_release = 1'b0;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      pointer <= '0;
      locked_index <= '0;
      beat_count <= '0;
    end else begin
      state <= state_next;
      pointer <= pointer_next;
      locked_index <= locked_index_next;
      beat_count <= beat_next;
    end
  always_comb begin
    state_next = state;
    pointer_next = pointer;
    locked_index_next = locked_index;
    beat_next = beat_count;
    if (release_burst || idle_release) begin
      state_next = IDLE;
      pointer_next = cur_next;
      beat_next = '0;
    end else if (transfer) begin
      state_next = LOCKED;
      locked_index_next = cur_index;
      beat_next = beat_count + 1'b1;
    end
  end
  always_comb begin
    grant = resetn ? cur_grant : '0;
    grant_index = resetn ? cur_index : '0;
    locked = resetn && state == LOCKED;
  end
endmodule

// File: tb/tb_burst_round_robin_arbiter.sv
// tb_burst_round_robin_arbiter: directed and randomized checks against a burst-ownership model.
module tb_burst_round_robin_arbiter;
  localparam int SIZE = 4;
  localparam int MAXB = 4;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [SIZE-1:0] requests = 4'b1111, lasts = '0;
  logic ready = 1'b0;
  logic [SIZE-1:0] grant;
  logic [1:0] grant_index;
  logic locked;
  int tests = 0, fails = 0;
  int owner = -1, beats = 0, ptr = 0, exp_idx = 0;
  logic [SIZE-1:0] exp_grant;
  logic [SIZE-1:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  burst_round_robin_arbiter #(.SIZE(SIZE), .MAX_BURST(MAXB), .IDLE_TIMEOUT(8)) dut (
    .clock(clock), .resetn(resetn), .requests(requests), .lasts(lasts), .ready(ready),
    .grant(grant), .grant_index(grant_index), .locked(locked)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_expect();
    exp_grant = '0;
    exp_idx = 0;
    if (owner >= 0) begin
      exp_idx = owner;
      exp_grant = 4'(1 << owner);
    end else
      for (int i = 0; i < SIZE; i++) begin
        int c;
        c = (ptr + i) % SIZE;
        if (requests[c]) begin
          exp_idx = c;
          exp_grant = 4'(1 << c);
          break;
        end
      end
  endtask

  task automatic model_update();
    int done;
    if ((exp_grant & requests) != 0 && ready) begin
      done = (owner < 0 ? 0 : beats) + 1;
      if (lasts[exp_idx] || done >= MAXB) begin
        owner = -1;
        beats = 0;
        ptr = (exp_idx + 1) % SIZE;
      end else begin
        owner = exp_idx;
        beats = done;
      end
    end
  endtask

  task automatic apply(input logic [SIZE-1:0] r, input logic [SIZE-1:0] l, input logic rd);
    requests = r;
    lasts = l;
    ready = rd;
    #2;
    model_expect();
    check("grant", grant, exp_grant);
    check("grant_index", grant_index, exp_idx);
    check("locked", locked, owner >= 0);
    model_update();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic [SIZE-1:0] r, input logic [SIZE-1:0] l, input logic rd);
    apply(r, l, rd);
    tick();
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    #1;
    owner = -1;
    beats = 0;
    ptr = 0;
    check("rst_grant", grant, 0);
    check("rst_index", grant_index, 0);
    check("rst_locked", locked, 0);
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    reset_dut();
    // single channel burst of three beats
    apply(4'b0100, 4'b0000, 1'b1);
    check("single_b1", grant, 4'b0100);
    tick();
    apply(4'b0100, 4'b0000, 1'b1);
    check("single_b2_locked", locked, 1);
    tick();
    apply(4'b0100, 4'b0100, 1'b1);
    check("single_b3_locked", locked, 1);
    tick();
    apply(4'b1111, 4'b1111, 1'b0);
    check("single_after_ptr3", grant, 4'b1000);
    check("single_after_idle", locked, 0);
    tick();
    // contention with single-beat bursts
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      apply(4'b1111, 4'b1111, 1'b1);
      check("rr_grant", grant, rr_seq[i]);
      tick();
    end
    // lock hold while owner drops its request
    reset_dut();
    step(4'b0010, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(4'b0001, 4'b0000, 1'b1);
      check("hold_grant", grant, 4'b0010);
      check("hold_locked", locked, 1);
      tick();
    end
    // forced release after MAXB beats
    reset_dut();
    for (int i = 0; i < MAXB; i++) begin
      apply(4'b0101, 4'b0000, 1'b1);
      check("force_grant", grant, 4'b0001);
      tick();
    end
    apply(4'b0101, 4'b0000, 1'b1);
    check("force_next", grant, 4'b0100);
    tick();
    // backpressure then mid-burst reset
    reset_dut();
    step(4'b1000, 4'b0000, 1'b1);
    step(4'b1000, 4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      apply(4'b1000, 4'b1000, 1'b0);
      check("bp_grant", grant, 4'b1000);
      tick();
    end
    reset_dut();
    apply(4'b1010, 4'b0000, 1'b1);
    check("post_reset_ptr0", grant, 4'b0010);
    tick();
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [SIZE-1:0] r, l;
      r = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'($urandom) & 4'($urandom);
      for (int b = 0; b < SIZE; b++) l[b] = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 199) == 0) reset_dut();
      else step(r, l, $urandom_range(0, 3) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
